// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite SRAM slave: word-organised memory with byte lanes,
// optional wait states and a two-cycle ERROR response.
module ahb3lite_sram_slave #(
  parameter int HADDR_SIZE  = 16,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [HDATA_SIZE-1:0] HRDATA
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_ERR1, S_ERR2
  } state_t;

  state_t          state;
  logic [2:0]      cnt;
  logic            dp_valid;
  logic            dp_write;
  logic [AW-1:0]   dp_idx;
  logic [3:0]      dp_be;

  logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

  logic                  accept;
  logic                  addr_err;
  logic                  wr_commit;
  logic [3:0]            be;
  logic [HADDR_SIZE-3:0] widx;
  logic                  unused_ok;

  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  assign widx   = HADDR[HADDR_SIZE-1:2];
  assign accept = HSEL && HREADY && HTRANS[1];

  always_comb begin
    be = 4'b0000;
    case (HSIZE)
      3'd0:    be = 4'b0001 << HADDR[1:0];
      3'd1:    be = HADDR[1] ? 4'b1100 : 4'b0011;
      3'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Range check uses the full word index so aliased addresses are refused.
  assign addr_err = (HSIZE > 3'd2)
                  || (HSIZE == 3'd1 && HADDR[0])
                  || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)
                  || (32'(widx) >= 32'(MEM_DEPTH));

  assign wr_commit = (state == S_IDLE) && dp_valid
                  && dp_write && HREADY;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= S_IDLE;
      cnt       <= 3'd0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      dp_idx    <= '0;
      dp_be     <= 4'b0000;
    end else begin
      unique case (state)
        S_IDLE, S_ERR2: begin
          if (HREADY) begin
            dp_valid <= accept && !addr_err;
            dp_write <= accept && !addr_err && HWRITE;
            dp_idx   <= HADDR[AW+1:2];
            dp_be    <= be;
            if (accept && addr_err) begin
              state     <= S_ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
            end else if (accept && WAIT_STATES != 0) begin
              state     <= S_WAIT;
              cnt       <= 3'(WAIT_STATES - 1);
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b0;
            end else begin
              state     <= S_IDLE;
              HREADYOUT <= 1'b1;
              HRESP     <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 3'd0) begin
            state     <= S_IDLE;
            HREADYOUT <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_ERR1: begin
          state     <= S_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
        end
      endcase
    end
  end

  // Memory has no reset; only completed OKAY writes touch it.
  always_ff @(posedge HCLK) begin
    if (!HRESET && wr_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (dp_be[i]) mem[dp_idx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if (state == S_IDLE && dp_valid && !dp_write) HRDATA = mem[dp_idx];
  end

endmodule

// File: tb/tb_ahb3lite_sram_slave.sv
// Bench for ahb3lite_sram_slave: three instances (0, 3, 5 wait
// states) driven by a simple AHB master, reads scored from a queue.
module tb_ahb3lite_sram_slave;

  logic        clk = 1'b0;
  logic        hreset = 1'b1;
  logic        hsel = 1'b0;
  logic [15:0] haddr = '0;
  logic [31:0] hwdata = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [1:0]  htrans = 2'b00;
  logic        force_lo = 1'b0;
  int          sel = 0;

  logic        hro [3];
  logic        hrs [3];
  logic [31:0] hrd [3];
  logic        hready;
  logic        ro, rs;
  logic [31:0] rd;

  assign ro = hro[sel];
  assign rs = hrs[sel];
  assign rd = hrd[sel];
  assign hready = force_lo ? 1'b0 : ro;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int WS = (k == 0) ? 0 : (k == 1) ? 3 : 5;
    ahb3lite_sram_slave #(
      .HADDR_SIZE(16), .HDATA_SIZE(32),
      .MEM_DEPTH(256), .WAIT_STATES(WS)
    ) u_dut (
      .HCLK(clk), .HRESET(hreset),
      .HSEL(hsel && sel == k), .HADDR(haddr),
      .HWDATA(hwdata), .HWRITE(hwrite),
      .HSIZE(hsize), .HBURST(3'b000),
      .HPROT(4'b0011), .HTRANS(htrans),
      .HMASTLOCK(1'b0), .HREADY(hready),
      .HREADYOUT(hro[k]), .HRESP(hrs[k]),
      .HRDATA(hrd[k])
    );
  end

  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] mdl [3][256];
  logic [31:0] exp_q [$];
  logic [31:0] e;
  int          b_lows;
  logic        b_r1, b_rsp;
  logic [31:0] b_rd;

  function automatic logic [31:0] merge(logic [31:0] o, logic [15:0] a,
                                        logic [2:0] sz, logic [31:0] d);
    logic [31:0] r;
    r = o;
    case (sz)
      3'd0:    r[8*a[1:0] +: 8] = d[8*a[1:0] +: 8];
      3'd1:    r[16*a[1] +: 16] = d[16*a[1] +: 16];
      default: r = d;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One non-pipelined transfer; records latency, response and read data.
  task automatic bus(input logic wr, input logic [15:0] a,
                     input logic [2:0] sz, input logic [31:0] wd);
    hsel = 1'b1; htrans = 2'b10; hwrite = wr;
    haddr = a; hsize = sz;
    tick();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    hwdata = wd;
    b_lows = 0;
    b_r1 = rs;
    while (!ro && b_lows < 20) begin
      tick();
      b_lows++;
    end
    b_rsp = rs;
    b_rd = rd;
    tick();
    hwdata = '0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [2:0] sz,
                          input logic [31:0] d);
    mdl[sel][a[9:2]] = merge(mdl[sel][a[9:2]], a, sz, d);
    bus(1'b1, a, sz, d);
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    tick(); tick();
    hreset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (hro[k] !== 1'b1) begin
        nerr++; $display("FAIL rst_ready[%0d] got %b want 1", k, hro[k]);
      end
      nvec++;
      if (hrs[k] !== 1'b0) begin
        nerr++; $display("FAIL rst_resp[%0d] got %b want 0", k, hrs[k]);
      end
      nvec++;
      if (hrd[k] !== 32'h0) begin
        nerr++; $display("FAIL rst_rdata[%0d] got %h want 0", k, hrd[k]);
      end
    end
  endtask

  task automatic test_word();
    sel = 0;
    do_write(16'h0010, 3'd2, 32'hDEADBEEF);
    nvec++;
    if (b_lows !== 0 || b_rsp !== 1'b0) begin
      nerr++; $display("FAIL word_wr lows/resp got %0d/%b want 0/0", b_lows, b_rsp);
    end
    nvec++;
    if (b_rd !== 32'h0) begin
      nerr++; $display("FAIL word_wr_rdata got %h want 0", b_rd);
    end
    exp_q.push_back(32'hDEADBEEF);
    bus(1'b0, 16'h0010, 3'd2, '0);
    e = exp_q.pop_front();
    nvec++;
    if (b_rd !== e || b_rsp !== 1'b0 || b_lows !== 0) begin
      nerr++; $display("FAIL word_rd got %h/%b/%0d want %h/0/0", b_rd, b_rsp, b_lows, e);
    end
  endtask

  task automatic test_byte_half();
    sel = 0;
    do_write(16'h0020, 3'd2, 32'h11223344);
    do_write(16'h0021, 3'd0, 32'hAAAAAAAA);
    do_write(16'h0022, 3'd1, 32'h55665566);
    exp_q.push_back(32'h5566AA44);
    bus(1'b0, 16'h0020, 3'd2, '0);
    e = exp_q.pop_front();
    nvec++;
    if (b_rd !== e) begin
      nerr++; $display("FAIL byte_half got %h want %h", b_rd, e);
    end
    do_write(16'h0024, 3'd2, 32'h01020304);
    do_write(16'h0027, 3'd0, 32'hF0F0F0F0);
    do_write(16'h0024, 3'd1, 32'h9ABC9ABC);
    exp_q.push_back(mdl[0][9]);
    bus(1'b0, 16'h0024, 3'd2, '0);
    e = exp_q.pop_front();
    nvec++;
    if (b_rd !== e) begin
      nerr++; $display("FAIL byte_half2 got %h want %h", b_rd, e);
    end
  endtask

  task automatic test_error();
    sel = 0;
    do_write(16'h0000, 3'd2, 32'hCAFEF00D);
    bus(1'b0, 16'h0002, 3'd2, '0);
    nvec++;
    if (b_lows !== 1 || b_r1 !== 1'b1 || b_rsp !== 1'b1) begin
      nerr++; $display("FAIL err_misalign got %0d/%b/%b want 1/1/1", b_lows, b_r1, b_rsp);
    end
    nvec++;
    if (b_rd !== 32'h0) begin
      nerr++; $display("FAIL err_rdata got %h want 0", b_rd);
    end
    bus(1'b1, 16'h0400, 3'd2, 32'h12345678);
    nvec++;
    if (b_lows !== 1 || b_r1 !== 1'b1 || b_rsp !== 1'b1) begin
      nerr++; $display("FAIL err_range got %0d/%b/%b want 1/1/1", b_lows, b_r1, b_rsp);
    end
    bus(1'b1, 16'h0001, 3'd1, 32'hFFFFFFFF);
    nvec++;
    if (b_lows !== 1 || b_rsp !== 1'b1) begin
      nerr++; $display("FAIL err_half got %0d/%b want 1/1", b_lows, b_rsp);
    end
    bus(1'b1, 16'h0000, 3'd3, 32'hFFFFFFFF);
    nvec++;
    if (b_lows !== 1 || b_rsp !== 1'b1) begin
      nerr++; $display("FAIL err_size got %0d/%b want 1/1", b_lows, b_rsp);
    end
    exp_q.push_back(32'hCAFEF00D);
    bus(1'b0, 16'h0000, 3'd2, '0);
    e = exp_q.pop_front();
    nvec++;
    if (b_rd !== e || b_rsp !== 1'b0) begin
      nerr++; $display("FAIL err_nowrite got %h/%b want %h/0", b_rd, b_rsp, e);
    end
  endtask

  task automatic test_back_to_back();
    sel = 0;
    do_write(16'h0040, 3'd2, 32'h11111111);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1;
    haddr = 16'h0040; hsize = 3'd2;
    tick();
    nvec++;
    if (ro !== 1'b1) begin
      nerr++; $display("FAIL b2b_wr_ready got %b want 1", ro);
    end
    hwrite = 1'b0; hwdata = 32'h0BADF00D;
    exp_q.push_back(32'h0BADF00D);
    tick();
    hsel = 1'b0; htrans = 2'b00; hwdata = '0;
    e = exp_q.pop_front();
    nvec++;
    if (ro !== 1'b1 || rs !== 1'b0 || rd !== e) begin
      nerr++; $display("FAIL b2b_rd got %b/%b/%h want 1/0/%h", ro, rs, rd, e);
    end
    mdl[0][16] = 32'h0BADF00D;
    tick();
  endtask

  task automatic test_wait();
    sel = 1;
    do_write(16'h0030, 3'd2, 32'hA5A5C3C3);
    nvec++;
    if (b_lows !== 3 || b_rsp !== 1'b0) begin
      nerr++; $display("FAIL wait_wr got %0d/%b want 3/0", b_lows, b_rsp);
    end
    exp_q.push_back(32'hA5A5C3C3);
    bus(1'b0, 16'h0030, 3'd2, '0);
    e = exp_q.pop_front();
    nvec++;
    if (b_lows !== 3 || b_rd !== e) begin
      nerr++; $display("FAIL wait_rd got %0d/%h want 3/%h", b_lows, b_rd, e);
    end
    bus(1'b0, 16'h0002, 3'd2, '0);
    nvec++;
    if (b_lows !== 1 || b_r1 !== 1'b1 || b_rsp !== 1'b1) begin
      nerr++; $display("FAIL wait_err got %0d/%b/%b want 1/1/1", b_lows, b_r1, b_rsp);
    end
  endtask

  task automatic test_idle_busy();
    sel = 1;
    hsel = 1'b1; hwrite = 1'b1; haddr = 16'h0030;
    hsize = 3'd2; hwdata = 32'hFFFFFFFF;
    for (int t = 0; t < 2; t++) begin
      htrans = 2'(t);
      tick();
      nvec++;
      if (ro !== 1'b1 || rs !== 1'b0) begin
        nerr++; $display("FAIL idle_busy[%0d] got %b/%b want 1/0", t, ro, rs);
      end
    end
    hsel = 1'b0; htrans = 2'b10;
    tick();
    nvec++;
    if (ro !== 1'b1 || rs !== 1'b0) begin
      nerr++; $display("FAIL unselected got %b/%b want 1/0", ro, rs);
    end
    hsel = 1'b1; force_lo = 1'b1;
    tick();
    force_lo = 1'b0; hsel = 1'b0; htrans = 2'b00;
    nvec++;
    if (ro !== 1'b1) begin
      nerr++; $display("FAIL hready_lo_accept got %b want 1", ro);
    end
    tick();
    hwdata = '0; hwrite = 1'b0;
    exp_q.push_back(mdl[1][12]);
    bus(1'b0, 16'h0030, 3'd2, '0);
    e = exp_q.pop_front();
    nvec++;
    if (b_rd !== e) begin
      nerr++; $display("FAIL idle_nowrite got %h want %h", b_rd, e);
    end
  endtask

  task automatic test_reset_mid();
    sel = 2;
    do_write(16'h0050, 3'd2, 32'h77777777);
    nvec++;
    if (b_lows !== 5) begin
      nerr++; $display("FAIL ws5_lows got %0d want 5", b_lows);
    end
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1;
    haddr = 16'h0050; hsize = 3'd2;
    tick();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    hwdata = 32'h99999999;
    tick();
    nvec++;
    if (ro !== 1'b0) begin
      nerr++; $display("FAIL mid_wait2 got %b want 0", ro);
    end
    hreset = 1'b1;
    tick();
    hreset = 1'b0; hwdata = '0;
    nvec++;
    if (ro !== 1'b1 || rs !== 1'b0) begin
      nerr++; $display("FAIL mid_rst got %b/%b want 1/0", ro, rs);
    end
    exp_q.push_back(32'h77777777);
    bus(1'b0, 16'h0050, 3'd2, '0);
    e = exp_q.pop_front();
    nvec++;
    if (b_rd !== e) begin
      nerr++; $display("FAIL mid_rst_mem got %h want %h", b_rd, e);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_error();
    test_back_to_back();
    test_wait();
    test_idle_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
